// File: rtl/dev_timer_pkg.sv
// rtl/dev_timer_pkg.sv - register map, CTRL fields, MODE and FSM encodings for dev_timer
package dev_timer_pkg;

   // Word offsets selected by Addr[3:2]
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   // CTRL bit positions; only CTRL[3:0] is stored
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;
   localparam int CTRL_W       = 4;

   // MODE encodings; 1x behaves as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   // Bridge address window occupied by this device (four words)
   localparam logic [31:0] DEV_TIMER_BEGIN = 32'h0000_7F00;
   localparam logic [31:0] DEV_TIMER_END   = 32'h0000_7F0F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   // Used by the bridge to decide whether an address belongs to this device
   function automatic logic in_window(input logic [31:0] addr);
      return (addr >= DEV_TIMER_BEGIN) && (addr <= DEV_TIMER_END);
   endfunction

   function automatic logic is_auto_reload(input logic [1:0] mode);
      return mode == MODE_AUTO;
   endfunction

endpackage

// File: rtl/dev_timer_if.sv
// rtl/dev_timer_if.sv - bridge-to-device register bus for dev_timer
interface dev_timer_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   // Bridge / CPU side
   modport master (
      output addr,
      output we,
      output din,
      input  dout,
      input  irq
   );

   // Device side
   modport slave (
      input  addr,
      input  we,
      input  din,
      output dout,
      output irq
   );
endinterface

// File: rtl/dev_timer.sv
// rtl/dev_timer.sv - memory-mapped countdown timer with level interrupt
module dev_timer
   import dev_timer_pkg::*;
#(
   parameter logic [31:0] PRESET_RST = 32'h0
)
(
   input  logic       clk_i,
   input  logic       reset_i,
   dev_timer_if.slave bus
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [31:0]       preset_q;
   logic [31:0]       count_q;
   logic [31:0]       count_d;
   logic              irq_flag_q;
   state_e            state_q;

   logic [1:0]        sel;
   logic              wr_ctrl;
   logic              wr_preset;
   logic              unused_addr_bits;

   assign sel              = bus.addr[3:2];
   assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};
   assign wr_ctrl          = bus.we && (sel == OFF_CTRL);
   assign wr_preset        = bus.we && (sel == OFF_PRESET);

   // Decremented count while counting; stops at 0 instead of wrapping
   always_comb begin
      count_d = '0;
      if (count_q > 32'd1) begin
         count_d = count_q - 32'd1;
      end
   end

   // Timer FSM plus register writes; CPU writes are placed last so they win over FSM updates
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ctrl_q     <= '0;
         preset_q   <= PRESET_RST;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (ctrl_q[CTRL_EN]) begin
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count_q <= preset_q;
               state_q <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_q[CTRL_EN]) begin
                  state_q <= ST_IDLE;
               end else if (count_q > 32'd1) begin
                  count_q <= count_d;
               end else begin
                  count_q    <= '0;
                  irq_flag_q <= 1'b1;
                  state_q    <= ST_INT;
               end
            end
            ST_INT: begin
               if (is_auto_reload(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                  irq_flag_q <= 1'b0;
               end else begin
                  ctrl_q[CTRL_EN] <= 1'b0;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (wr_ctrl) begin
            ctrl_q     <= bus.din[CTRL_W-1:0];
            irq_flag_q <= 1'b0;
         end
         if (wr_preset) begin
            preset_q <= bus.din;
         end
      end
   end

   // Zero-latency read mux; reserved slot reads as zero
   always_comb begin
      bus.dout = '0;
      unique case (sel)
         OFF_CTRL:   bus.dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
         OFF_PRESET: bus.dout = preset_q;
         OFF_COUNT:  bus.dout = count_q;
         default:    bus.dout = '0;
      endcase
   end

   assign bus.irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_dev_timer.sv
// tb/tb_dev_timer.sv - self-checking bench for dev_timer
module tb_dev_timer;
   import dev_timer_pkg::*;

   localparam logic [31:0] P_RST = 32'h1234_5678;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   dev_timer_if bus();

   dev_timer #(.PRESET_RST(P_RST)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Random upper/lower address bits: only Addr[3:2] may matter
   task automatic write_reg(input logic [1:0] off, input logic [31:0] data);
      logic [31:0] r;
      r        = $urandom;
      bus.addr = {r[31:4], off, r[1:0]};
      bus.din  = data;
      bus.we   = 1'b1;
      @(posedge clk);
      #1;
      bus.we   = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] off, output logic [31:0] data);
      logic [31:0] r;
      r        = $urandom;
      bus.addr = {r[31:4], off, r[1:0]};
      #1;
      data = bus.dout;
   endtask

   // Reference timeline: k = edges after the enabling CTRL write
   function automatic int oneshot_count(input int n, input int k);
      int fire;
      fire = ((n > 1) ? n : 1) + 2;
      if (k < 2 || k >= fire) return 0;
      return n - (k - 2);
   endfunction

   function automatic bit oneshot_irq(input int n, input int k);
      return k >= (((n > 1) ? n : 1) + 2);
   endfunction

   function automatic int auto_count(input int n, input int k);
      int p;
      if (k < 2) return 0;
      p = (k - 2) % (n + 3);
      return (p < n) ? n - p : 0;
   endfunction

   function automatic bit auto_irq(input int n, input int k);
      return (k >= n + 2) && (((k - n - 2) % (n + 3)) == 0);
   endfunction

   initial begin
      logic [31:0] rd;
      logic [31:0] v;
      logic [1:0]  mode;
      int          n;
      int          r;

      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.we   = 1'b0;
      bus.addr = '0;
      bus.din  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values
      read_reg(OFF_CTRL, rd);   chk("rst_ctrl", rd, 32'h0);
      read_reg(OFF_PRESET, rd); chk("rst_preset", rd, P_RST);
      read_reg(OFF_COUNT, rd);  chk("rst_count", rd, 32'h0);
      read_reg(OFF_RSVD, rd);   chk("rst_rsvd", rd, 32'h0);
      chk("rst_irq", {31'b0, bus.irq}, 32'h0);

      // One-shot runs: first with PRESET 0/1, then random; MODE 00, 10 or 11
      for (int t = 0; t < 3; t++) begin
         n    = (t == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
         r    = int'($urandom_range(0, 2));
         mode = (r == 0) ? 2'b00 : 2'(r + 1);
         write_reg(OFF_PRESET, 32'(n));
         write_reg(OFF_CTRL, {28'h0, 1'b1, mode, 1'b1});
         for (int k = 1; k <= ((n > 1) ? n : 1) + 3; k++) begin
            tick(1);
            read_reg(OFF_COUNT, rd);
            chk("oneshot_count", rd, 32'(oneshot_count(n, k)));
            chk("oneshot_irq", {31'b0, bus.irq}, oneshot_irq(n, k) ? 32'd1 : 32'd0);
         end
         read_reg(OFF_CTRL, rd);
         chk("oneshot_ctrl_en_cleared", rd, {28'h0, 1'b1, mode, 1'b0});
         write_reg(OFF_CTRL, 32'h8);
         chk("oneshot_irq_ack", {31'b0, bus.irq}, 32'h0);
      end

      // Auto-reload: pulses every n+3 cycles, EN stays set
      n = int'($urandom_range(1, 6));
      write_reg(OFF_PRESET, 32'(n));
      write_reg(OFF_CTRL, 32'hB);
      for (int k = 1; k <= 3 * n + 9; k++) begin
         tick(1);
         read_reg(OFF_COUNT, rd);
         chk("auto_count", rd, 32'(auto_count(n, k)));
         chk("auto_irq", {31'b0, bus.irq}, auto_irq(n, k) ? 32'd1 : 32'd0);
      end
      read_reg(OFF_CTRL, rd);
      chk("auto_ctrl", rd, 32'hB);
      write_reg(OFF_CTRL, 32'h0);
      tick(4);

      // Masked interrupt
      write_reg(OFF_PRESET, 32'd2);
      write_reg(OFF_CTRL, 32'h1);
      tick(4);
      read_reg(OFF_COUNT, rd);
      chk("mask_count", rd, 32'h0);
      chk("mask_irq", {31'b0, bus.irq}, 32'h0);
      tick(1);
      read_reg(OFF_CTRL, rd);
      chk("mask_ctrl", rd, 32'h0);
      write_reg(OFF_CTRL, 32'h8);
      chk("mask_irq_after_im", {31'b0, bus.irq}, 32'h0);
      tick(1);
      chk("mask_irq_stays", {31'b0, bus.irq}, 32'h0);

      // Pause/resume with PRESET rewritten mid-count
      write_reg(OFF_PRESET, 32'd10);
      write_reg(OFF_CTRL, 32'h1);
      tick(6);
      read_reg(OFF_COUNT, rd); chk("pause_count6", rd, 32'd6);
      write_reg(OFF_PRESET, 32'd2);
      read_reg(OFF_COUNT, rd); chk("pause_count5", rd, 32'd5);
      write_reg(OFF_CTRL, 32'h0);
      read_reg(OFF_COUNT, rd); chk("pause_count4", rd, 32'd4);
      tick(3);
      read_reg(OFF_COUNT, rd); chk("pause_frozen", rd, 32'd4);
      write_reg(OFF_CTRL, 32'h1);
      tick(2);
      read_reg(OFF_COUNT, rd); chk("resume_reload", rd, 32'd2);
      tick(2);
      read_reg(OFF_COUNT, rd); chk("resume_zero", rd, 32'd0);
      chk("resume_irq_masked", {31'b0, bus.irq}, 32'h0);
      tick(2);
      read_reg(OFF_CTRL, rd);  chk("resume_ctrl", rd, 32'h0);

      // CPU write in the cycle the FSM enters INT
      write_reg(OFF_PRESET, 32'd3);
      write_reg(OFF_CTRL, 32'h9);
      tick(4);
      read_reg(OFF_COUNT, rd); chk("coll_count1", rd, 32'd1);
      write_reg(OFF_CTRL, 32'hB);
      read_reg(OFF_CTRL, rd);  chk("coll_ctrl", rd, 32'hB);
      read_reg(OFF_COUNT, rd); chk("coll_count0", rd, 32'd0);
      chk("coll_irq", {31'b0, bus.irq}, 32'h0);
      tick(3);
      read_reg(OFF_COUNT, rd); chk("coll_reload", rd, 32'd3);

      // Reset mid-count with a simultaneous CTRL write
      bus.addr = {28'h0, OFF_CTRL, 2'b00};
      bus.din  = 32'hF;
      bus.we   = 1'b1;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      bus.we = 1'b0;
      read_reg(OFF_CTRL, rd);   chk("mid_rst_ctrl", rd, 32'h0);
      read_reg(OFF_PRESET, rd); chk("mid_rst_preset", rd, P_RST);
      read_reg(OFF_COUNT, rd);  chk("mid_rst_count", rd, 32'h0);
      chk("mid_rst_irq", {31'b0, bus.irq}, 32'h0);
      tick(3);
      read_reg(OFF_COUNT, rd);  chk("mid_rst_idle", rd, 32'h0);

      // Random register writes: COUNT and reserved ignored, CTRL keeps 4 bits
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         write_reg(OFF_COUNT, v);
         read_reg(OFF_COUNT, rd);  chk("rb_count_ro", rd, 32'h0);
         write_reg(OFF_PRESET, v);
         read_reg(OFF_PRESET, rd); chk("rb_preset", rd, v);
         write_reg(OFF_RSVD, ~v);
         read_reg(OFF_RSVD, rd);   chk("rb_rsvd", rd, 32'h0);
         read_reg(OFF_PRESET, rd); chk("rb_preset_kept", rd, v);
         write_reg(OFF_CTRL, v & ~32'h1);
         read_reg(OFF_CTRL, rd);   chk("rb_ctrl", rd, v & 32'hE);
         chk("rb_irq", {31'b0, bus.irq}, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dev_timer.md
Name: dev_timer

Overview:
- Memory-mapped countdown timer; the responder at the device end of the system bridge's DEV bus (DEV_Addr/DEV_WD/DEV_WE/DEV_RD).
- Registers are written and read by the CPU through the bridge.
- Counts down from a preset value and raises an interrupt line towards the CPU's exception logic.
- Occupies one bridge device slot; register decode uses Addr[3:2] only.

Parameters:
PRESET_RST, 32'h0, reset value of the PRESET register

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Addr  input  32  device address from bridge (DEV_Addr); only [3:2] decoded
WE  input  1  write enable for this device (bridge-qualified DEVn_WE)
Din  input  32  write data (DEV_WD)
Dout  output  32  read data (DEVn_RD), combinational from Addr[3:2]
IRQ  output  1  interrupt request, level, active-high

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL
  - 1 = PRESET
  - 2 = COUNT (read-only)
  - 3 = reserved, reads 0, writes ignored
- CTRL fields:
  - [0] EN
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot
  - [3] IM (interrupt mask, 1 = enabled)
  - CTRL[31:4] not stored, read 0
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0, IRQ=0; Dout shows those values.
- Write: when WE=1 at a clk edge, the register selected by Addr[3:2] takes Din. Writes to COUNT and reserved are ignored.
- Any CTRL write clears irq_flag.
- Read: Dout = selected register, zero-latency combinational.
- IRQ = irq_flag & CTRL[3], combinational from registers.
- FSM states (2-bit): IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: EN=0 -> IDLE, COUNT frozen. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1, -> INT.
  - INT, MODE one-shot: EN<=0, irq_flag held, -> IDLE.
  - INT, MODE auto-reload: irq_flag<=0, EN unchanged, -> IDLE.
- Latency, with PRESET=N≥1 and EN written at edge 0:
  - COUNT=N after edge 2.
  - COUNT=1 after edge N+1.
  - COUNT=0 and irq_flag=1 after edge N+2.
  - Auto-reload: IRQ is a one-cycle pulse every N+3 cycles.
- PRESET=0 or 1: CNT goes to INT on its first cycle; COUNT=0, IRQ after edge 3.
- PRESET write while counting: no effect on COUNT until the next LOAD.
- Simultaneous CPU write to CTRL and FSM update of EN/irq_flag in the same cycle: the CPU write wins for CTRL. irq_flag is cleared even if the FSM sets it that cycle.
- EN cleared by software mid-count: next edge -> IDLE, COUNT keeps its value. Re-enable reloads from PRESET.
- reset asserted mid-operation: all state returns to reset values on that edge, irrespective of WE.
- COUNT never wraps below 0.

Decomposition:
- Shared header: register offsets (CTRL/PRESET/COUNT), CTRL bit indices, MODE encodings, FSM state encodings, and the device's address window begin/end used by the bridge decode.
- Single module; no sub-module needed.

Test Plan:
- Reset values: reset=1 for 2 cycles -> Dout=0 at offsets 0x0/0x8, 0x4 reads PRESET_RST, IRQ=0.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, mode 0, IM) at edge 0 -> COUNT reads 5 after edge 2, 0 after edge 7, IRQ=1 from edge 7 and held. CTRL reads 0x8. A CTRL write of 0x8 drops IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ one-cycle pulses after edges 5, 11, 17. COUNT reloads to 3 between pulses. EN stays 1.
- Mask: PRESET=2, CTRL=0x1 -> irq_flag set after edge 4 but IRQ=0. Writing CTRL=0x8 clears the flag -> IRQ stays 0.
- Pause/resume and mid-count PRESET: PRESET=10 and start. After COUNT=6, write PRESET=2 -> count continues 5,4,... Clear EN at COUNT=4 -> COUNT stays 4. Set EN -> COUNT reloads to 2.
- Collision/reset: a CTRL write in the same cycle the FSM enters INT -> CTRL equals the written value, irq_flag=0. Assert reset at COUNT=3 -> all registers reset, IRQ=0.
